// File: rtl/seletor_base_rpn.sv
// Push-button base selector for the RPN display path: synchronise, debounce,
// then step DEC -> OCT -> HEX -> DEC once per accepted press.
module seletor_base_rpn #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic       Clock,
  input  logic       Reset_n,
  input  logic       Botao,
  input  logic       Habilita,
  output logic [1:0] Base,
  output logic [2:0] LedBase,
  output logic       Mudou
);

  typedef enum logic [1:0] {
    ST_DEC = 2'b00,
    ST_OCT = 2'b01,
    ST_HEX = 2'b10
  } base_state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_accepted;
  logic             r_accepted_dly;
  logic [CNT_W-1:0] r_cnt;
  base_state_t      r_state;
  logic [2:0]       r_led;
  logic             r_mudou;

  base_state_t      w_state_nxt;
  logic [2:0]       w_led_nxt;
  logic             w_mudou_nxt;
  logic             w_press;
  logic             w_advance;

  // Button idles high, so the synchroniser and accepted level start "released";
  // a button held through reset is then seen as a fresh press.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, exactly like the hardware.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= Botao;
      r_sync2 <= r_sync1;
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive disagreeing
  // samples; any return to the accepted level restarts the count.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_accepted     <= 1'b1;
      r_accepted_dly <= 1'b1;
      r_cnt          <= '0;
    end else begin
      r_accepted_dly <= r_accepted;
      if (r_sync2 == r_accepted) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_accepted <= r_sync2;
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign w_press   = r_accepted_dly & ~r_accepted;
  assign w_advance = w_press & Habilita;

  // NOTE: every always_comb output gets a default first, so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_mudou_nxt = 1'b0;
    case (r_state)
      ST_DEC: if (w_advance) begin
        w_state_nxt = ST_OCT;
        w_mudou_nxt = 1'b1;
      end
      ST_OCT: if (w_advance) begin
        w_state_nxt = ST_HEX;
        w_mudou_nxt = 1'b1;
      end
      ST_HEX: if (w_advance) begin
        w_state_nxt = ST_DEC;
        w_mudou_nxt = 1'b1;
      end
      default: w_state_nxt = ST_DEC;
    endcase

    case (w_state_nxt)
      ST_OCT:  w_led_nxt = 3'b010;
      ST_HEX:  w_led_nxt = 3'b100;
      default: w_led_nxt = 3'b001;
    endcase
  end

  // LEDs are registered alongside the state so the outputs never glitch.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_DEC;
      r_led   <= 3'b001;
      r_mudou <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_led   <= w_led_nxt;
      r_mudou <= w_mudou_nxt;
    end
  end

  assign Base    = r_state;
  assign LedBase = r_led;
  assign Mudou   = r_mudou;

endmodule

// File: tb/tb_seletor_base_rpn.sv
// Scoreboard bench for seletor_base_rpn: a window-based reference model predicts
// base changes, a monitor pops predictions whenever Mudou pulses.
module tb_seletor_base_rpn;

  localparam int DC    = 4;
  localparam int CNT_W = 3;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       botao   = 1'b1;
  logic       hab     = 1'b1;
  logic [1:0] base;
  logic [2:0] led;
  logic       mudou;

  int vectors     = 0;
  int miscompares = 0;

  seletor_base_rpn #(.DEBOUNCE_CYCLES(DC), .CNT_W(CNT_W)) dut (
    .Clock   (clk),
    .Reset_n (rst_n),
    .Botao   (botao),
    .Habilita(hab),
    .Base    (base),
    .LedBase (led),
    .Mudou   (mudou)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] led_of(input int b);
    return 3'b001 << b;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [1:0] base;
    logic [2:0] led;
  } exp_t;

  exp_t sb[$];
  bit   raw[$];   // raw button samples, oldest first
  bit   win[$];   // synchronised samples since the last acceptance
  bit   m_acc;
  bit   m_press;
  int   m_base;
  bit   sp;
  bit   all_diff;

  // A level is accepted when the last DC synchronised samples all differ from
  // the accepted level; a falling acceptance is a press, acted on one edge later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw.delete();
      raw.push_back(1'b1);
      raw.push_back(1'b1);
      win.delete();
      sb.delete();
      m_acc   = 1'b1;
      m_press = 1'b0;
      m_base  = 0;
    end else begin
      if (m_press && hab) begin
        m_base = (m_base + 1) % 3;
        sb.push_back('{base: 2'(m_base), led: led_of(m_base)});
      end
      sp = raw[raw.size()-2];
      raw.push_back(botao);
      if (raw.size() > 8) void'(raw.pop_front());
      win.push_back(sp);
      if (win.size() > DC) void'(win.pop_front());
      all_diff = (win.size() == DC);
      foreach (win[i]) if (win[i] == m_acc) all_diff = 1'b0;
      m_press = 1'b0;
      if (all_diff) begin
        m_press = m_acc & ~sp;
        m_acc   = sp;
        win.delete();
      end
    end
  end

  // ---------------- monitor ----------------
  exp_t e;
  always @(negedge clk) begin
    if (rst_n) begin
      check("base_level", base, m_base);
      check("led_level", led, led_of(m_base));
      if (mudou) begin
        if (sb.size() == 0) begin
          check("spurious_mudou", 1, 0);
        end else begin
          e = sb.pop_front();
          check("mudou_base", base, e.base);
          check("mudou_led", led, e.led);
        end
      end
      if (sb.size() != 0) begin
        check("missing_mudou", sb.size(), 0);
        sb.delete();
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int hold, input int gap);
    botao = 1'b0;
    cycles(hold);
    botao = 1'b1;
    cycles(gap);
  endtask

  initial begin
    int tries;
    #12;
    check("reset_base", base, 2'b00);
    check("reset_led", led, 3'b001);
    check("reset_mudou", mudou, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(3);

    // single long press, then three clean presses (wrap)
    press(20, 12);
    repeat (3) press(10, 10);

    // glitches shorter than the debounce window
    botao = 1'b0; cycles(3);
    botao = 1'b1; cycles(2);
    botao = 1'b0; cycles(3);
    botao = 1'b1; cycles(10);

    // bounce, then stable low
    repeat (8) begin
      botao = ~botao;
      cycles(1);
    end
    botao = 1'b0; cycles(10);
    botao = 1'b1; cycles(10);

    // enable gating: press consumed while disabled, not replayed later
    hab = 1'b0;
    botao = 1'b0; cycles(10);
    hab = 1'b1; cycles(5);
    botao = 1'b1; cycles(10);
    press(10, 10);

    // randomized button and enable activity
    repeat (300) begin
      botao = 1'($urandom_range(0, 1));
      hab   = ($urandom_range(0, 7) != 0);
      cycles($urandom_range(1, 8));
    end
    botao = 1'b1;
    hab   = 1'b1;
    cycles(12);

    // reach HEX, then reset asynchronously mid-debounce with the button held
    tries = 0;
    while (m_base != 2 && tries < 4) begin
      press(10, 10);
      tries++;
    end
    check("reached_hex", base, 2'b10);
    botao = 1'b0;
    cycles(2);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_base", base, 2'b00);
    check("async_reset_led", led, 3'b001);
    check("async_reset_mudou", mudou, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(15);
    check("held_through_reset", base, 2'b01);
    botao = 1'b1;
    cycles(10);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
